// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller:
// RV32I opcodes, forwarding selects, FSM states, decode helpers.
package hazard_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN      = 1'b0,
        BR_STALL = 1'b1
    } hz_state_t;

    function automatic logic is_ctl(input logic [6:0] op);
        return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_BRANCH) || (op == OP_STORE) || (op == OP_OP);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// EX operand forwarding compare for one source operand.
// Ports: ex_rs (EX source reg), MEM/WB rd + reg_write, sel (fwd_sel_t).
module fwd_unit
    import hazard_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_reg_write,
    output fwd_sel_t         sel
);

    // MEM holds the younger result, so it wins over WB; x0 never forwards.
    always_comb begin
        sel = FWD_RF;
        if (mem_reg_write && (mem_rd == ex_rs) && (mem_rd != '0))
            sel = FWD_MEM;
        else if (wb_reg_write && (wb_rd == ex_rs) && (wb_rd != '0))
            sel = FWD_WB;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: load-use interlock,
// EX forwarding selects, branch freeze / predict-not-taken flush policy,
// saturating stall/flush counter and sticky branch-resolve timeout flag.
// Ports: clk, rst (sync, active-high); ID instr, EX/MEM/WB register info,
// EX branch resolve; outputs PC/IF-ID enables, IF-ID/ID-EX flushes,
// fwd_a/fwd_b, stall_cnt, hazard_err.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int BRANCH_MODE = 0,
    parameter int MAX_STALL   = 4,
    parameter int PERF_W      = 32,
    parameter int REG_W       = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       id_instr,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_mem_read,
    input  logic [REG_W-1:0]  ex_rs1,
    input  logic [REG_W-1:0]  ex_rs2,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic              mem_reg_write,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic              wb_reg_write,
    input  logic              ex_br_valid,
    input  logic              ex_br_taken,
    input  logic              perf_clr,
    output logic              pc_enable,
    output logic              ifid_enable,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [PERF_W-1:0] stall_cnt,
    output logic              hazard_err
);

    localparam int CW = $clog2(MAX_STALL + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_STALL);

    hz_state_t       state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            err_set;
    fwd_sel_t        sel_a, sel_b;

    logic [6:0]       op;
    logic [REG_W-1:0] id_rs1, id_rs2;
    logic             lu, ctl, stall_ev;
    logic             unused_bits;

    assign op     = id_instr[6:0];
    assign id_rs1 = REG_W'(id_instr[19:15]);
    assign id_rs2 = REG_W'(id_instr[24:20]);
    assign ctl    = is_ctl(op);
    assign unused_bits = ^{id_instr[31:25], id_instr[14:7]};

    assign lu = ex_mem_read && (ex_rd != '0) &&
                (((ex_rd == id_rs1) && uses_rs1(op)) ||
                 ((ex_rd == id_rs2) && uses_rs2(op)));

    fwd_unit #(.REG_W(REG_W)) u_fwd_a (
        .ex_rs         (ex_rs1),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .sel           (sel_a)
    );

    fwd_unit #(.REG_W(REG_W)) u_fwd_b (
        .ex_rs         (ex_rs2),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .sel           (sel_b)
    );

    assign fwd_a = rst ? FWD_RF : sel_a;
    assign fwd_b = rst ? FWD_RF : sel_b;

    always_comb begin
        pc_enable   = 1'b1;
        ifid_enable = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        state_n     = state;
        cnt_n       = cnt;
        err_set     = 1'b0;
        if (!rst) begin
            unique case (state)
                RUN: begin
                    if (BRANCH_MODE == 1 && ex_br_valid && ex_br_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (lu) begin
                        // Hold PC and ID; bubble into EX until the load data exists.
                        pc_enable   = 1'b0;
                        ifid_enable = 1'b0;
                        idex_flush  = 1'b1;
                    end else if (BRANCH_MODE == 0 && ctl) begin
                        // Let the branch advance, freeze fetch behind it.
                        pc_enable  = 1'b0;
                        ifid_flush = 1'b1;
                        cnt_n      = CW'(1);
                        state_n    = BR_STALL;
                    end
                end
                BR_STALL: begin
                    pc_enable  = 1'b0;
                    ifid_flush = 1'b1;
                    if (ex_br_valid) begin
                        pc_enable = 1'b1;
                        state_n   = RUN;
                    end else if (cnt == MAX_C) begin
                        pc_enable = 1'b1;
                        err_set   = 1'b1;
                        state_n   = RUN;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: state_n = RUN;
            endcase
        end
    end

    assign stall_ev = !pc_enable || ifid_flush || idex_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            cnt        <= '0;
            stall_cnt  <= '0;
            hazard_err <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (err_set)
                hazard_err <= 1'b1;
            if (perf_clr)
                stall_cnt <= '0;
            else if (stall_ev && (stall_cnt != '1))
                stall_cnt <= stall_cnt + PERF_W'(1);
        end
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised hazard controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
- Replaces the fixed one-cycle branch freeze with three functions:
  - load-use interlock;
  - EX operand forwarding select;
  - a branch policy selected by mode: freeze-until-resolve, or predict-not-taken with flush.
- Also provides a saturating stall/flush performance counter and a sticky resolve-timeout error flag.
- Sits beside the pipeline registers; drives the PC and IF/ID enables and the IF/ID and ID/EX flushes.

Parameters:
- BRANCH_MODE, 0, 0 = freeze fetch from decode until EX resolves; 1 = predict not taken, flush on taken.
- MAX_STALL, 4, maximum BR_STALL cycles before forced exit and hazard_err (>=1).
- PERF_W, 32, width of the stall_cnt performance counter.
- REG_W, 5, register-index width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous active-high reset.
- id_instr  in  32  instruction currently in the ID stage.
- ex_rd  in  REG_W  destination register of the EX-stage instruction.
- ex_mem_read  in  1  EX-stage instruction is a load.
- ex_rs1  in  REG_W  rs1 of the EX-stage instruction (forwarding).
- ex_rs2  in  REG_W  rs2 of the EX-stage instruction (forwarding).
- mem_rd  in  REG_W  MEM-stage destination register.
- mem_reg_write  in  1  MEM-stage instruction writes a register.
- wb_rd  in  REG_W  WB-stage destination register.
- wb_reg_write  in  1  WB-stage instruction writes a register.
- ex_br_valid  in  1  control-flow instruction in EX resolves this cycle.
- ex_br_taken  in  1  the resolved branch is taken (qualified by ex_br_valid).
- perf_clr  in  1  synchronous clear of stall_cnt.
- pc_enable  out  1  PC register load enable.
- ifid_enable  out  1  IF/ID register load enable.
- ifid_flush  out  1  load a NOP into IF/ID.
- idex_flush  out  1  load a NOP (bubble) into ID/EX.
- fwd_a  out  2  EX operand A select: 00 register file, 10 MEM, 01 WB.
- fwd_b  out  2  EX operand B select, same encoding as fwd_a.
- stall_cnt  out  PERF_W  saturating count of stall or flush cycles.
- hazard_err  out  1  sticky; a BR_STALL timeout has occurred.

Behaviour:
- Reset and register timing:
  - Reset is synchronous and active-high on clk; all state updates on posedge clk.
  - While rst=1: pc_enable=1, ifid_enable=1, flushes=0, fwd=00.
  - On the reset edge: state<=RUN, counter<=0, stall_cnt<=0, hazard_err<=0.
- Control outputs are combinational from state and inputs (zero latency). stall_cnt and hazard_err are registered.
- Decode of id_instr[6:0]:
  - Control-flow (ctl) opcodes: 1100011, 1101111, 1100111.
  - Uses rs1 unless the opcode is 0110111, 0010111 or 1101111.
  - Uses rs2 for 1100011, 0100011 and 0110011.
- Load-use (lu) is asserted when all of the following hold:
  - ex_mem_read=1 and ex_rd != 0;
  - ex_rd matches id_instr[19:15] with rs1 in use, or matches id_instr[24:20] with rs2 in use.
- Forwarding (fwd_a uses ex_rs1; fwd_b uses ex_rs2 identically):
  - 10 if mem_reg_write and mem_rd == ex_rs1 and mem_rd != 0;
  - else 01 if wb_reg_write and wb_rd == ex_rs1 and wb_rd != 0;
  - else 00.
  - MEM has priority over WB. x0 is never forwarded. Forwarding is independent of state.
- State machine states: RUN, BR_STALL. BR_STALL is used only when BRANCH_MODE=0.
- RUN, priority high to low:
  - (a) BRANCH_MODE=1 and ex_br_valid and ex_br_taken: ifid_flush=1, idex_flush=1, pc_enable=1 (PC loads the target).
  - (b) lu: pc_enable=0, ifid_enable=0, idex_flush=1. The ID instruction is held and re-evaluated next cycle.
  - (c) BRANCH_MODE=0 and ctl in ID: the instruction advances; pc_enable=0, ifid_flush=1; counter<=1; go to BR_STALL.
  - (d) Otherwise all enables are 1 and all flushes are 0.
- BR_STALL:
  - Default each cycle: pc_enable=0, ifid_enable=1, ifid_flush=1, idex_flush=0.
  - On ex_br_valid: pc_enable=1 (PC loads the resolved next-PC), ifid_flush=1, go to RUN.
  - Else if counter == MAX_STALL: pc_enable=1, hazard_err<=1, go to RUN.
  - Else counter<=counter+1.
  - Counter width is $clog2(MAX_STALL+1).
- stall_cnt:
  - Increments in every non-reset cycle where pc_enable=0, ifid_flush=1 or idex_flush=1.
  - Saturates at all-ones.
  - perf_clr sets it to 0 and takes priority over the increment.
- hazard_err clears only on rst.
- Reset mid-BR_STALL returns to RUN with no stale flush on the following cycle.

Decomposition:
- Put in the shared package hazard_pkg:
  - opcode constants OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_STORE, OP_OP;
  - enum fwd_sel_t {FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10};
  - enum hz_state_t {RUN, BR_STALL}.
- Sub-module fwd_unit contains the pure combinational forwarding compare and is instantiated once per operand.

Test Plan:
- Load-use:
  - Stimulus: ex_mem_read=1, ex_rd=5, id_instr=ADD x7,x5,x6.
  - Response: pc_enable=0, ifid_enable=0, idex_flush=1 for one cycle; stall_cnt=1. With ex_rd=0 there is no stall.
- Forward priority:
  - Stimulus: mem_rd=wb_rd=3, both reg_write=1, ex_rs1=3, ex_rs2=0.
  - Response: fwd_a=10, fwd_b=00. With mem_reg_write=0: fwd_a=01.
- Mode 0 branch:
  - Stimulus: BEQ in ID; ex_br_valid=1 two cycles later.
  - Response: pc_enable is 0,0 then 1 on the resolve cycle; ifid_flush=1 for all 3 cycles; state returns to RUN; stall_cnt=3.
- Mode 0 timeout:
  - Stimulus: MAX_STALL=2, JAL in ID, ex_br_valid held 0.
  - Response: pc_enable=1 in the third cycle and hazard_err=1 thereafter. Deassert and reassert rst mid-stall -> all outputs at reset values and hazard_err=0.
- Mode 1 taken branch:
  - Stimulus: ex_br_valid=1, ex_br_taken=1 together with lu true.
  - Response: flush has priority: ifid_flush=idex_flush=1, pc_enable=1. With taken=0: normal flow.
- Counter:
  - Stimulus: PERF_W=4, 20 consecutive stall cycles.
  - Response: stall_cnt saturates at 15; perf_clr on the same cycle as a stall -> 0.
